// File: rtl/ld_st_buffer_pkg.sv
// Shared definitions for the load/store buffer.
// Contents: ROB tag sizing, lw/sw opcode encodings, head-controller state
// encoding, and an opcode classifier used by the enqueue logic.
package ld_st_buffer_pkg;

  localparam int ROB_SIZE_bits = 3;

  localparam logic [11:0] OP_LW = 12'h8C0;
  localparam logic [11:0] OP_SW = 12'hAC0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_REQ   = 3'd1,
    LD_WB    = 3'd2,
    ST_BCAST = 3'd3,
    ST_WAIT  = 3'd4,
    ST_WR    = 3'd5
  } lsb_state_e;

  function automatic logic is_ldst(input logic [11:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/ld_st_buffer_entry.sv
// One load/store buffer slot: holds the decoded ld/st and snoops the CDB
// for its outstanding base (tag1) and store-data (tag2) operands.
// Ports:
//   clk, rst            clock, async active-high reset
//   flush_i             squash: drop the entry
//   wr_i                enqueue into this slot (operands snooped same cycle)
//   clr_i               dequeue this slot
//   *_i payload         is_st, rd, roben, tag1/val1, tag2/val2, imm
//   cdb_*_i             CDB snoop
//   *_o                 registered slot contents
module ld_st_entry
  import ld_st_buffer_pkg::*;
#(
  parameter int ROBW = ROB_SIZE_bits + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            wr_i,
  input  logic            clr_i,
  input  logic            is_st_i,
  input  logic [4:0]      rd_i,
  input  logic [ROBW-1:0] roben_i,
  input  logic [ROBW-1:0] tag1_i,
  input  logic [31:0]     val1_i,
  input  logic [ROBW-1:0] tag2_i,
  input  logic [31:0]     val2_i,
  input  logic [31:0]     imm_i,
  input  logic            cdb_valid_i,
  input  logic [ROBW-1:0] cdb_roben_i,
  input  logic [31:0]     cdb_data_i,
  output logic            valid_o,
  output logic            is_st_o,
  output logic [4:0]      rd_o,
  output logic [ROBW-1:0] roben_o,
  output logic [ROBW-1:0] tag1_o,
  output logic [31:0]     val1_o,
  output logic [ROBW-1:0] tag2_o,
  output logic [31:0]     val2_o,
  output logic [31:0]     imm_o
);

  logic            valid_q, valid_d, is_st_q, is_st_d;
  logic [4:0]      rd_q, rd_d;
  logic [ROBW-1:0] roben_q, roben_d, tag1_q, tag1_d, tag2_q, tag2_d;
  logic [31:0]     val1_q, val1_d, val2_q, val2_d, imm_q, imm_d;

  // Snoop applies to whichever operand copy will be stored this edge, so an
  // operand produced on the CDB in the enqueue cycle is not missed.
  logic [ROBW-1:0] t1_src, t2_src;
  logic [31:0]     v1_src, v2_src;
  logic            hit1, hit2;

  assign t1_src = wr_i ? tag1_i : tag1_q;
  assign t2_src = wr_i ? tag2_i : tag2_q;
  assign v1_src = wr_i ? val1_i : val1_q;
  assign v2_src = wr_i ? val2_i : val2_q;
  assign hit1   = cdb_valid_i && (t1_src != '0) && (cdb_roben_i == t1_src);
  assign hit2   = cdb_valid_i && (t2_src != '0) && (cdb_roben_i == t2_src);

  always_comb begin
    valid_d = valid_q;
    is_st_d = is_st_q;
    rd_d    = rd_q;
    roben_d = roben_q;
    tag1_d  = tag1_q;
    val1_d  = val1_q;
    tag2_d  = tag2_q;
    val2_d  = val2_q;
    imm_d   = imm_q;
    if (wr_i) begin
      valid_d = 1'b1;
      is_st_d = is_st_i;
      rd_d    = rd_i;
      roben_d = roben_i;
      imm_d   = imm_i;
    end
    if (wr_i || valid_q) begin
      tag1_d = hit1 ? '0 : t1_src;
      val1_d = hit1 ? cdb_data_i : v1_src;
      tag2_d = hit2 ? '0 : t2_src;
      val2_d = hit2 ? cdb_data_i : v2_src;
    end
    if (clr_i || flush_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      is_st_q <= 1'b0;
      rd_q    <= '0;
      roben_q <= '0;
      tag1_q  <= '0;
      val1_q  <= '0;
      tag2_q  <= '0;
      val2_q  <= '0;
      imm_q   <= '0;
    end else begin
      valid_q <= valid_d;
      is_st_q <= is_st_d;
      rd_q    <= rd_d;
      roben_q <= roben_d;
      tag1_q  <= tag1_d;
      val1_q  <= val1_d;
      tag2_q  <= tag2_d;
      val2_q  <= val2_d;
      imm_q   <= imm_d;
    end
  end

  assign valid_o = valid_q;
  assign is_st_o = is_st_q;
  assign rd_o    = rd_q;
  assign roben_o = roben_q;
  assign tag1_o  = tag1_q;
  assign val1_o  = val1_q;
  assign tag2_o  = tag2_q;
  assign val2_o  = val2_q;
  assign imm_o   = imm_q;

endmodule

// File: rtl/ld_st_buffer.sv
// In-order load/store buffer. Entries are enqueued from the address unit,
// wait on the CDB for operands, and are retired strictly from the head:
// loads read memory then broadcast; stores broadcast, wait for ROB commit,
// then write memory.
// Ports:
//   clk, rst                      clock, async active-high reset
//   AU_LdStB_*                    enqueue request and operands
//   CDB_*                         CDB snoop
//   ROB_Commit_*                  ROB head commit (releases stores)
//   FLUSH                         squash everything
//   MEM_RDATA                     read data, one cycle after MEM_REN
//   LdStB_FULL                    buffer full
//   LdStB_MEM_*                   memory request
//   LdStB_CDB_*                   result broadcast
module ld_st_buffer
  import ld_st_buffer_pkg::*;
#(
  parameter int BUFFER_SIZE = 4,
  parameter int ROBW        = ROB_SIZE_bits + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            AU_LdStB_VALID_Inst,
  input  logic [ROBW-1:0] AU_LdStB_ROBEN,
  input  logic [4:0]      AU_LdStB_Rd,
  input  logic [11:0]     AU_LdStB_opcode,
  input  logic [ROBW-1:0] AU_LdStB_ROBEN1,
  input  logic [ROBW-1:0] AU_LdStB_ROBEN2,
  input  logic [31:0]     AU_LdStB_ROBEN1_VAL,
  input  logic [31:0]     AU_LdStB_ROBEN2_VAL,
  input  logic [31:0]     AU_LdStB_Immediate,
  input  logic            CDB_VALID,
  input  logic [ROBW-1:0] CDB_ROBEN,
  input  logic [31:0]     CDB_Write_Data,
  input  logic            ROB_Commit_VALID,
  input  logic [ROBW-1:0] ROB_Commit_ROBEN,
  input  logic            FLUSH,
  input  logic [31:0]     MEM_RDATA,
  output logic            LdStB_FULL,
  output logic            LdStB_MEM_REN,
  output logic            LdStB_MEM_WEN,
  output logic [31:0]     LdStB_MEM_ADDR,
  output logic [31:0]     LdStB_MEM_WDATA,
  output logic            LdStB_CDB_VALID,
  output logic [ROBW-1:0] LdStB_CDB_ROBEN,
  output logic [4:0]      LdStB_CDB_Rd,
  output logic [31:0]     LdStB_CDB_DATA
);

  localparam int AW = $clog2(BUFFER_SIZE);

  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  lsb_state_e    state_q, state_d;
  logic          enq, deq;

  logic            e_valid [BUFFER_SIZE];
  logic            e_is_st [BUFFER_SIZE];
  logic [4:0]      e_rd    [BUFFER_SIZE];
  logic [ROBW-1:0] e_roben [BUFFER_SIZE];
  logic [ROBW-1:0] e_tag1  [BUFFER_SIZE];
  logic [31:0]     e_val1  [BUFFER_SIZE];
  logic [ROBW-1:0] e_tag2  [BUFFER_SIZE];
  logic [31:0]     e_val2  [BUFFER_SIZE];
  logic [31:0]     e_imm   [BUFFER_SIZE];

  assign LdStB_FULL = (count_q == (AW+1)'(BUFFER_SIZE));
  // Full blocks enqueue even if the head retires this same cycle.
  assign enq = AU_LdStB_VALID_Inst && is_ldst(AU_LdStB_opcode) && !LdStB_FULL && !FLUSH;

  for (genvar i = 0; i < BUFFER_SIZE; i++) begin : g_ent
    ld_st_entry #(.ROBW(ROBW)) u_entry (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (FLUSH),
      .wr_i        (enq && (tail_q == AW'(i))),
      .clr_i       (deq && (head_q == AW'(i))),
      .is_st_i     (AU_LdStB_opcode == OP_SW),
      .rd_i        (AU_LdStB_Rd),
      .roben_i     (AU_LdStB_ROBEN),
      .tag1_i      (AU_LdStB_ROBEN1),
      .val1_i      (AU_LdStB_ROBEN1_VAL),
      .tag2_i      (AU_LdStB_ROBEN2),
      .val2_i      (AU_LdStB_ROBEN2_VAL),
      .imm_i       (AU_LdStB_Immediate),
      .cdb_valid_i (CDB_VALID),
      .cdb_roben_i (CDB_ROBEN),
      .cdb_data_i  (CDB_Write_Data),
      .valid_o     (e_valid[i]),
      .is_st_o     (e_is_st[i]),
      .rd_o        (e_rd[i]),
      .roben_o     (e_roben[i]),
      .tag1_o      (e_tag1[i]),
      .val1_o      (e_val1[i]),
      .tag2_o      (e_tag2[i]),
      .val2_o      (e_val2[i]),
      .imm_o       (e_imm[i])
    );
  end

  // Head view
  logic            h_valid, h_is_st;
  logic [4:0]      h_rd;
  logic [ROBW-1:0] h_roben, h_tag1, h_tag2;
  logic [31:0]     h_val2, h_ea;

  assign h_valid = e_valid[head_q];
  assign h_is_st = e_is_st[head_q];
  assign h_rd    = e_rd[head_q];
  assign h_roben = e_roben[head_q];
  assign h_tag1  = e_tag1[head_q];
  assign h_tag2  = e_tag2[head_q];
  assign h_val2  = e_val2[head_q];
  assign h_ea    = e_val1[head_q] + e_imm[head_q];

  // Pointers and occupancy; FLUSH wins over any enqueue/dequeue.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (FLUSH) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + AW'(1);
      if (deq) head_d = head_q + AW'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Head controller. Outputs depend on state only (plus MEM_RDATA in LD_WB),
  // so an ST_WR cycle coinciding with FLUSH still issues its write.
  always_comb begin
    state_d         = state_q;
    deq             = 1'b0;
    LdStB_MEM_REN   = 1'b0;
    LdStB_MEM_WEN   = 1'b0;
    LdStB_MEM_ADDR  = '0;
    LdStB_MEM_WDATA = '0;
    LdStB_CDB_VALID = 1'b0;
    LdStB_CDB_ROBEN = '0;
    LdStB_CDB_Rd    = '0;
    LdStB_CDB_DATA  = '0;
    case (state_q)
      IDLE: begin
        if (h_valid && !h_is_st && (h_tag1 == '0))
          state_d = LD_REQ;
        else if (h_valid && h_is_st && (h_tag1 == '0) && (h_tag2 == '0))
          state_d = ST_BCAST;
      end
      LD_REQ: begin
        LdStB_MEM_REN  = 1'b1;
        LdStB_MEM_ADDR = h_ea;
        state_d        = LD_WB;
      end
      LD_WB: begin
        LdStB_CDB_VALID = 1'b1;
        LdStB_CDB_ROBEN = h_roben;
        LdStB_CDB_Rd    = h_rd;
        LdStB_CDB_DATA  = MEM_RDATA;
        deq             = 1'b1;
        state_d         = IDLE;
      end
      ST_BCAST: begin
        LdStB_CDB_VALID = 1'b1;
        LdStB_CDB_ROBEN = h_roben;
        LdStB_CDB_DATA  = h_val2;
        state_d         = ST_WAIT;
      end
      ST_WAIT: begin
        if (ROB_Commit_VALID && (ROB_Commit_ROBEN == h_roben)) state_d = ST_WR;
      end
      ST_WR: begin
        LdStB_MEM_WEN   = 1'b1;
        LdStB_MEM_ADDR  = h_ea;
        LdStB_MEM_WDATA = h_val2;
        deq             = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (FLUSH) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_ld_st_buffer.sv
module tb_ld_st_buffer;
  import ld_st_buffer_pkg::*;

  localparam int RW = ROB_SIZE_bits + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          vld;
  logic [RW-1:0] rob, r1, r2, cdb_rob, cm_rob;
  logic [4:0]    rd;
  logic [11:0]   op;
  logic [31:0]   v1, v2, imm, cdb_data, rdata;
  logic          cdb_v, cm_v, flush;
  logic          full, ren, wen, ocv;
  logic [31:0]   addr, wdata, odata;
  logic [RW-1:0] orob;
  logic [4:0]    ord;

  always #5 clk = ~clk;

  ld_st_buffer dut (
    .clk(clk), .rst(rst),
    .AU_LdStB_VALID_Inst(vld), .AU_LdStB_ROBEN(rob), .AU_LdStB_Rd(rd),
    .AU_LdStB_opcode(op), .AU_LdStB_ROBEN1(r1), .AU_LdStB_ROBEN2(r2),
    .AU_LdStB_ROBEN1_VAL(v1), .AU_LdStB_ROBEN2_VAL(v2), .AU_LdStB_Immediate(imm),
    .CDB_VALID(cdb_v), .CDB_ROBEN(cdb_rob), .CDB_Write_Data(cdb_data),
    .ROB_Commit_VALID(cm_v), .ROB_Commit_ROBEN(cm_rob), .FLUSH(flush),
    .MEM_RDATA(rdata), .LdStB_FULL(full), .LdStB_MEM_REN(ren), .LdStB_MEM_WEN(wen),
    .LdStB_MEM_ADDR(addr), .LdStB_MEM_WDATA(wdata), .LdStB_CDB_VALID(ocv),
    .LdStB_CDB_ROBEN(orob), .LdStB_CDB_Rd(ord), .LdStB_CDB_DATA(odata)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [108:0] outs();
    return {full, ren, wen, addr, wdata, ocv, orob, ord, odata};
  endfunction

  // Background monitors (sampled on the falling edge)
  logic          collect = 1'b0, watch = 1'b0;
  logic [RW-1:0] seen[$];
  int            n_ren = 0, n_wen = 0, n_cv = 0;
  always @(negedge clk) begin
    if (collect && ocv) seen.push_back(orob);
    if (watch) begin
      n_ren <= n_ren + int'(ren);
      n_wen <= n_wen + int'(wen);
      n_cv  <= n_cv + int'(ocv);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    vld = 0; rob = '0; rd = '0; op = '0; r1 = '0; r2 = '0; v1 = '0; v2 = '0; imm = '0;
    cdb_v = 0; cdb_rob = '0; cdb_data = '0; cm_v = 0; cm_rob = '0; flush = 0; rdata = '0;
  endtask

  task automatic enq_op(input logic [11:0] o, input logic [RW-1:0] rb, input logic [4:0] d,
                        input logic [RW-1:0] t1, input logic [31:0] a, input logic [RW-1:0] t2,
                        input logic [31:0] b, input logic [31:0] im);
    vld = 1; op = o; rob = rb; rd = d; r1 = t1; v1 = a; r2 = t2; v2 = b; imm = im;
  endtask

  typedef struct {
    string         nm;
    logic          vld;
    logic [11:0]   op;
    logic [RW-1:0] rob;
    logic [4:0]    rd;
    logic [RW-1:0] t1;
    logic [31:0]   v1;
    logic [RW-1:0] t2;
    logic [31:0]   v2;
    logic [31:0]   imm;
    logic          cm;
    logic [RW-1:0] cmrob;
    logic          fl;
    logic [31:0]   rdata;
    logic          e_ren, e_wen;
    logic [31:0]   e_addr, e_wd;
    logic          e_cv;
    logic [RW-1:0] e_rob;
    logic [4:0]    e_rd;
    logic [31:0]   e_cd;
  } vec_t;

  vec_t rows[$];

  task automatic r(input string nm, input logic vl, input logic [11:0] o, input logic [RW-1:0] rb,
                   input logic [4:0] d, input logic [RW-1:0] t1, input logic [31:0] a,
                   input logic [RW-1:0] t2, input logic [31:0] b, input logic [31:0] im,
                   input logic cm, input logic [RW-1:0] cr, input logic fl, input logic [31:0] rdv,
                   input logic eren, input logic ewen, input logic [31:0] eaddr, input logic [31:0] ewd,
                   input logic ecv, input logic [RW-1:0] erob, input logic [4:0] erd, input logic [31:0] ecd);
    vec_t v;
    v.nm = nm; v.vld = vl; v.op = o; v.rob = rb; v.rd = d; v.t1 = t1; v.v1 = a; v.t2 = t2;
    v.v2 = b; v.imm = im; v.cm = cm; v.cmrob = cr; v.fl = fl; v.rdata = rdv;
    v.e_ren = eren; v.e_wen = ewen; v.e_addr = eaddr; v.e_wd = ewd;
    v.e_cv = ecv; v.e_rob = erob; v.e_rd = erd; v.e_cd = ecd;
    rows.push_back(v);
  endtask

  initial begin
    logic [RW-1:0] exp_order[5];
    int k;
    exp_order[0] = 4'd1; exp_order[1] = 4'd2; exp_order[2] = 4'd3;
    exp_order[3] = 4'd4; exp_order[4] = 4'd6;

    //  name         vld op     rob rd t1 v1       t2 v2       imm    cm cr fl rdata          ren wen addr     wdata    cv rob rd cdata
    r("lw_enq",      1, OP_LW,  1, 5, 0, 32'h100, 0, 32'h0,   32'h4, 0, 0, 0, 32'h0,         0, 0, 32'h0,   32'h0,   0, 0, 0, 32'h0);
    r("lw_wait",     0, 12'h0,  0, 0, 0, 32'h0,   0, 32'h0,   32'h0, 0, 0, 0, 32'h0,         0, 0, 32'h0,   32'h0,   0, 0, 0, 32'h0);
    r("lw_req",      0, 12'h0,  0, 0, 0, 32'h0,   0, 32'h0,   32'h0, 0, 0, 0, 32'h0,         1, 0, 32'h104, 32'h0,   0, 0, 0, 32'h0);
    r("lw_wb",       0, 12'h0,  0, 0, 0, 32'h0,   0, 32'h0,   32'h0, 0, 0, 0, 32'hCAFEBABE,  0, 0, 32'h0,   32'h0,   1, 1, 5, 32'hCAFEBABE);
    r("sw_enq",      1, OP_SW,  2, 7, 0, 32'h40,  0, 32'hDEAD,32'h8, 0, 0, 0, 32'h0,         0, 0, 32'h0,   32'h0,   0, 0, 0, 32'h0);
    r("sw_wait",     0, 12'h0,  0, 0, 0, 32'h0,   0, 32'h0,   32'h0, 0, 0, 0, 32'h0,         0, 0, 32'h0,   32'h0,   0, 0, 0, 32'h0);
    r("sw_bcast",    0, 12'h0,  0, 0, 0, 32'h0,   0, 32'h0,   32'h0, 0, 0, 0, 32'h0,         0, 0, 32'h0,   32'h0,   1, 2, 0, 32'hDEAD);
    r("sw_bad_cmt",  0, 12'h0,  0, 0, 0, 32'h0,   0, 32'h0,   32'h0, 1, 3, 0, 32'h1234,      0, 0, 32'h0,   32'h0,   0, 0, 0, 32'h0);
    r("sw_commit",   0, 12'h0,  0, 0, 0, 32'h0,   0, 32'h0,   32'h0, 1, 2, 0, 32'h0,         0, 0, 32'h0,   32'h0,   0, 0, 0, 32'h0);
    r("sw_write",    0, 12'h0,  0, 0, 0, 32'h0,   0, 32'h0,   32'h0, 0, 0, 0, 32'h0,         0, 1, 32'h48,  32'hDEAD,0, 0, 0, 32'h0);
    r("empty_idle",  0, 12'h0,  0, 0, 0, 32'h0,   0, 32'h0,   32'h0, 0, 0, 0, 32'h0,         0, 0, 32'h0,   32'h0,   0, 0, 0, 32'h0);
    r("bad_op",      1, 12'h123,3, 1, 0, 32'h500, 0, 32'h0,   32'h0, 0, 0, 0, 32'h0,         0, 0, 32'h0,   32'h0,   0, 0, 0, 32'h0);
    r("bad_op_n1",   0, 12'h0,  0, 0, 0, 32'h0,   0, 32'h0,   32'h0, 0, 0, 0, 32'h0,         0, 0, 32'h0,   32'h0,   0, 0, 0, 32'h0);
    r("bad_op_n2",   0, 12'h0,  0, 0, 0, 32'h0,   0, 32'h0,   32'h0, 0, 0, 0, 32'h0,         0, 0, 32'h0,   32'h0,   0, 0, 0, 32'h0);
    r("flush_enq",   1, OP_LW,  3, 1, 0, 32'h600, 0, 32'h0,   32'h0, 0, 0, 1, 32'h0,         0, 0, 32'h0,   32'h0,   0, 0, 0, 32'h0);
    r("flush_n1",    0, 12'h0,  0, 0, 0, 32'h0,   0, 32'h0,   32'h0, 0, 0, 0, 32'h0,         0, 0, 32'h0,   32'h0,   0, 0, 0, 32'h0);
    r("flush_n2",    0, 12'h0,  0, 0, 0, 32'h0,   0, 32'h0,   32'h0, 0, 0, 0, 32'h0,         0, 0, 32'h0,   32'h0,   0, 0, 0, 32'h0);

    // Reset state
    idle();
    rst = 1;
    #1 chk("reset_outs", outs(), '0);
    tick(); tick();
    rst = 0;

    // Table-driven cycle trace
    foreach (rows[i]) begin
      vld = rows[i].vld; op = rows[i].op; rob = rows[i].rob; rd = rows[i].rd;
      r1 = rows[i].t1; v1 = rows[i].v1; r2 = rows[i].t2; v2 = rows[i].v2; imm = rows[i].imm;
      cm_v = rows[i].cm; cm_rob = rows[i].cmrob; flush = rows[i].fl; rdata = rows[i].rdata;
      #2 chk(rows[i].nm, outs(), {1'b0, rows[i].e_ren, rows[i].e_wen, rows[i].e_addr, rows[i].e_wd,
                                  rows[i].e_cv, rows[i].e_rob, rows[i].e_rd, rows[i].e_cd});
      tick();
    end
    idle();

    // lw waiting on ROBEN1=3, negative offset
    enq_op(OP_LW, 4, 9, 3, 32'h0, 0, 32'h0, 32'hFFFF_FFFC); tick(); idle();
    #1 chk("lwdep_hold0", ren, 0); tick();
    cdb_v = 1; cdb_rob = 3; cdb_data = 32'h200;
    #1 chk("lwdep_hold1", ren, 0); tick(); idle();
    #1 chk("lwdep_capture", ren, 0); tick();
    chk("lwdep_addr", {ren, addr}, {1'b1, 32'h1FC}); tick();
    rdata = 32'h55;
    #1 chk("lwdep_wb", {ocv, orob, ord, odata}, {1'b1, 4'd4, 5'd9, 32'h55}); tick(); idle();

    // Operand produced on the CDB in the very cycle of enqueue
    enq_op(OP_LW, 5, 2, 6, 32'h0, 0, 32'h0, 32'h10);
    cdb_v = 1; cdb_rob = 6; cdb_data = 32'h300; tick(); idle();
    #1 chk("samecyc_idle", ren, 0); tick();
    chk("samecyc_addr", {ren, addr}, {1'b1, 32'h310}); tick();
    chk("samecyc_wb", {ocv, orob, ord}, {1'b1, 4'd5, 5'd2}); tick();

    // Fill, overflow drop, drain, wrap
    seen.delete();
    collect = 1;
    for (int i = 1; i <= 4; i++) begin
      enq_op(OP_LW, RW'(i), 5'(i), 5, 32'h0, 0, 32'h0, 32'(i * 4)); tick();
    end
    idle();
    #1 chk("full_set", full, 1);
    enq_op(OP_LW, 7, 7, 0, 32'h3000, 0, 32'h0, 32'h0);
    #1 chk("full_on_drop", full, 1); tick(); idle();
    cdb_v = 1; cdb_rob = 5; cdb_data = 32'h1000; tick(); idle();
    k = 0;
    while (full && k < 20) begin tick(); k++; end
    chk("full_release", full, 0);
    enq_op(OP_LW, 6, 6, 0, 32'h2000, 0, 32'h0, 32'h0); tick(); idle();
    repeat (30) tick();
    collect = 0;
    chk("order_len", seen.size(), 5);
    for (int i = 0; i < 5 && i < seen.size(); i++)
      chk($sformatf("order_%0d", i), seen[i], exp_order[i]);

    // FLUSH while a store waits for commit, 3 entries buffered
    enq_op(OP_SW, 1, 0, 0, 32'h80, 0, 32'hBEEF, 32'h0); tick();
    enq_op(OP_LW, 2, 2, 9, 32'h0, 0, 32'h0, 32'h0); tick();
    enq_op(OP_LW, 3, 3, 9, 32'h0, 0, 32'h0, 32'h0); tick(); idle();
    #1 chk("stwait_quiet", {ren, wen, ocv}, 3'b000);
    flush = 1; cm_v = 1; cm_rob = 1; tick(); idle();
    n_ren = 0; n_wen = 0; n_cv = 0; watch = 1;
    #1 chk("flush_empty", full, 0);
    cm_v = 1; cm_rob = 1; cdb_v = 1; cdb_rob = 9; cdb_data = 32'h77; tick(); idle();
    repeat (8) tick();
    watch = 0;
    chk("flush_no_strobe", {n_ren[7:0], n_wen[7:0], n_cv[7:0]}, 24'h0);
    enq_op(OP_LW, 4, 4, 0, 32'h700, 0, 32'h0, 32'h0); tick(); idle(); tick();
    chk("post_flush_ld", {ren, addr}, {1'b1, 32'h700}); tick(); tick();

    // Reset asserted while a load is in LD_REQ
    enq_op(OP_LW, 5, 3, 0, 32'h900, 0, 32'h0, 32'h0); tick(); idle(); tick();
    chk("pre_rst_req", {ren, addr}, {1'b1, 32'h900});
    rst = 1;
    #1 chk("rst_outs", outs(), '0);
    rdata = 32'hFFFF; tick();
    rst = 0;
    n_ren = 0; n_wen = 0; n_cv = 0; watch = 1;
    repeat (5) tick();
    watch = 0;
    chk("rst_no_bcast", {n_ren[7:0], n_wen[7:0], n_cv[7:0]}, 24'h0);
    chk("rst_full", full, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
